// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding AXI-lite read master feeding decode over valid/ready.
// Define IFU_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic        discard_q, discard_d;
  logic        ar_hs, r_hs;
  logic [31:0] redirect_tgt;

  assign arvalid    = (state_q == StAddr);
  assign rready     = (state_q == StData);
  assign inst_valid = (state_q == StHold);
  assign araddr     = araddr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  assign ar_hs        = arvalid && arready;
  assign r_hs         = rready && rvalid;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    discard_d    = discard_q;

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) pc_d = redirect_tgt;
        state_d = StAddr;
      end
      StAddr: begin
        // The in-flight AR keeps its latched address; its response will be dropped.
        if (redirect_valid) begin
          pc_d      = redirect_tgt;
          discard_d = 1'b1;
        end
        if (ar_hs) state_d = StData;
      end
      StData: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt;
          discard_d = 1'b1;
        end
        if (r_hs) begin
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
            state_d   = StAddr;
          end else begin
            inst_d       = rdata;
            inst_pc_d    = pc_q;
            inst_fault_d = (rresp != 2'b00);
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        // Redirect flushes the held instruction even if decode accepts it this cycle.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = StAddr;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = StAddr;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StAddr) && (state_d == StAddr)) araddr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      discard_q    <= discard_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inst_valid && inst_ready && !redirect_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((arvalid && !arready) || (rready && !rvalid)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; AXI-lite read master directly upstream of the instruction SRAM slave.
- Holds the PC and issues one read per instruction on AR, consumes the response on R, and presents the instruction to the decode stage over a valid/ready handshake.
- Accepts redirects (jump/branch/exception target) from later stages.
- One outstanding transaction at a time; the AW/W/B channels are not part of this block.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction value driven on inst when no valid instruction is held.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- araddr  out  32  read address (AXI-lite AR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready from SRAM.
- rdata  in  32  read data.
- rresp  in  2  read response; 2'b00 = OKAY.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- inst  out  32  fetched instruction to decode.
- inst_pc  out  32  PC of inst.
- inst_fault  out  1  fetch returned non-OKAY rresp.
- inst_valid  out  1  inst/inst_pc/inst_fault valid.
- inst_ready  in  1  decode accepts.
- redirect_valid  in  1  redirect request, single-cycle pulse or level.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, arvalid=0, rready=0, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC, inst_fault=0, discard=0.
- States: IDLE, ADDR, DATA, HOLD. All outputs are registered or decoded from state only; no combinational path from any input to arvalid, rready or inst_valid.
- IDLE: lasts exactly one cycle after reset release, then ->ADDR.
- ADDR: arvalid=1, araddr=pc.
  - araddr is stable while arvalid=1; arvalid is never dropped before arready.
  - On arvalid&&arready -> DATA.
- DATA: rready=1.
  - On rvalid&&rready: capture rdata->inst, rresp!=0 ->inst_fault, pc->inst_pc.
  - If discard=0: ->HOLD.
  - If discard=1: drop the data, clear discard, ->ADDR (pc already updated).
- HOLD: inst_valid=1.
  - On inst_valid&&inst_ready: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), ->ADDR.
  - inst_valid falls to 0 the cycle after the handshake.
- Latency with an SRAM of one WAIT cycle: AR handshake in cycle N, R handshake in cycle N+2, inst_valid in cycle N+3. Best case is 1 cycle ADDR->DATA, 1 cycle DATA->HOLD.
- Redirect (sampled only when redirect_valid=1 at a clock edge; has priority over all else):
  - IDLE: pc<=redirect_pc; IDLE->ADDR continues as normal.
  - ADDR: pc<=redirect_pc; the in-flight AR is completed with its original address, and discard<=1.
    - If the AR handshake happens in the same cycle: discard<=1, ->DATA.
    - Otherwise remain in ADDR and keep the original araddr (latched) until handshake; the next fetch uses the new pc.
  - DATA: pc<=redirect_pc, discard<=1; if rvalid in the same cycle, drop the data and ->ADDR directly.
  - HOLD: inst_valid<=0, pc<=redirect_pc, ->ADDR. The held instruction is flushed even if inst_ready=1 that cycle; decode ignores inst in any cycle where redirect_valid=1.
  - Back-to-back redirects: the last one wins; discard stays 1 until one response has been dropped.
- A fault response is not retried: inst_fault=1 is forwarded with inst=rdata, and pc advances normally on handshake.
- inst holds its value while inst_valid=0. inst=NOP_INST only after reset.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each inst handshake.
  - perf_stall_cnt increments every cycle state is ADDR or DATA and no handshake occurs on that channel.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Release reset, SRAM 1-cycle wait, inst_ready=1 -> araddr=32'h8000_0000, then 32'h8000_0004, 32'h8000_0008; inst_pc matches; one instruction per 4 cycles.
- inst_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst/inst_pc stable, arvalid=0, no new AR.
- arready low 3 cycles, redirect_valid pulse (redirect_pc=32'h8000_0100) in the 2nd of them -> araddr stays 32'h8000_0000 until handshake, response dropped (no inst_valid), next araddr=32'h8000_0100.
- Redirect to 32'h8000_0203 during HOLD with inst_ready=1 -> inst flushed, next araddr=32'h8000_0200.
- rresp=2'b10 with rdata=32'hDEAD_BEEF -> inst_fault=1, inst=32'hDEAD_BEEF; next fetch at pc+4.
- Assert rst_n=0 asynchronously mid-DATA -> arvalid/rready/inst_valid go 0 immediately; after release, fetch restarts at RESET_PC. With IFU_PERF_CNT_EN, the counters read 0.
